// File: rtl/irq_pipeline_ctrl.sv
// Interrupt entry / mret return sequencer for the 5-stage RV32I pipeline.
// Drains the pipeline, saves the return PC, redirects fetch to mtvec, then back to mepc on mret.
module irq_pipeline_ctrl #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_irq,
    input  logic            i_mie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_ex_valid,
    input  logic            i_pc_sel,
    input  logic            i_hazard_stall,
    input  logic            i_mret_ex,
    output logic            o_pc_en,
    output logic            o_flush_id_n,
    output logic            o_flush_ex_n,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_mepc_we,
    output logic [XLEN-1:0] o_mepc,
    output logic            o_mie_clr,
    output logic            o_mie_set,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic            take;

    logic            pc_en_reg, flush_id_n_reg, flush_ex_n_reg, redirect_reg;
    logic            mepc_we_reg, mie_clr_reg, mie_set_reg, busy_reg;
    logic [XLEN-1:0] redirect_pc_reg;

    // A request blocked by a branch, stall or mret is simply retried while the level holds.
    assign take = i_irq & i_mie & i_ex_valid & ~i_pc_sel & ~i_hazard_stall & ~i_mret_ex;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mepc_next  = mepc_reg;
        case (state_reg)
            IDLE: begin
                if (i_mret_ex) begin
                    state_next = RETURN;
                end else if (take) begin
                    state_next = DRAIN;
                    mepc_next  = i_ex_pc;
                    cnt_next   = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_reg == 4'd0) begin
                    state_next = REDIRECT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            REDIRECT: state_next = HANDLER;
            HANDLER:  if (i_mret_ex) state_next = RETURN;
            RETURN:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            mepc_reg        <= '0;
            pc_en_reg       <= 1'b1;
            flush_id_n_reg  <= 1'b1;
            flush_ex_n_reg  <= 1'b1;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            mepc_we_reg     <= 1'b0;
            mie_clr_reg     <= 1'b0;
            mie_set_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            mepc_reg        <= mepc_next;
            pc_en_reg       <= 1'b1;
            flush_id_n_reg  <= 1'b1;
            flush_ex_n_reg  <= 1'b1;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            mepc_we_reg     <= 1'b0;
            mie_clr_reg     <= 1'b0;
            mie_set_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            case (state_next)
                DRAIN: begin
                    pc_en_reg      <= 1'b0;
                    flush_id_n_reg <= 1'b0;
                    flush_ex_n_reg <= 1'b0;
                    busy_reg       <= 1'b1;
                end
                REDIRECT: begin
                    redirect_reg    <= 1'b1;
                    redirect_pc_reg <= i_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
                    mepc_we_reg     <= 1'b1;
                    mie_clr_reg     <= 1'b1;
                    flush_id_n_reg  <= 1'b0;
                    busy_reg        <= 1'b1;
                end
                RETURN: begin
                    redirect_reg    <= 1'b1;
                    redirect_pc_reg <= mepc_next;
                    flush_id_n_reg  <= 1'b0;
                    flush_ex_n_reg  <= 1'b0;
                    mie_set_reg     <= 1'b1;
                    busy_reg        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pc_en       = pc_en_reg;
    assign o_flush_id_n  = flush_id_n_reg;
    assign o_flush_ex_n  = flush_ex_n_reg;
    assign o_redirect    = redirect_reg;
    assign o_redirect_pc = redirect_pc_reg;
    assign o_mepc_we     = mepc_we_reg;
    assign o_mepc        = mepc_reg;
    assign o_mie_clr     = mie_clr_reg;
    assign o_mie_set     = mie_set_reg;
    assign o_busy        = busy_reg;

endmodule

// File: tb/tb_irq_pipeline_ctrl.sv
// Directed bench for irq_pipeline_ctrl: entry, deferral, return, reset abort.
module tb_irq_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, irq, mie, ex_valid, pc_sel, hazard_stall, mret_ex;
    logic [31:0] mtvec, ex_pc;
    logic        pc_en, flush_id_n, flush_ex_n, redirect, mepc_we, mie_clr, mie_set, busy;
    logic [31:0] redirect_pc, mepc;

    int total = 0;
    int bad   = 0;

    // Output bundle order: pc_en, flush_id_n, flush_ex_n, redirect, mepc_we, mie_clr, mie_set, busy
    localparam logic [7:0] O_IDLE  = 8'b1110_0000;
    localparam logic [7:0] O_DRAIN = 8'b0000_0001;
    localparam logic [7:0] O_REDIR = 8'b1011_1101;
    localparam logic [7:0] O_RET   = 8'b1001_0011;

    always #5 clk = ~clk;

    irq_pipeline_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_irq          (irq),
        .i_mie          (mie),
        .i_mtvec        (mtvec),
        .i_ex_pc        (ex_pc),
        .i_ex_valid     (ex_valid),
        .i_pc_sel       (pc_sel),
        .i_hazard_stall (hazard_stall),
        .i_mret_ex      (mret_ex),
        .o_pc_en        (pc_en),
        .o_flush_id_n   (flush_id_n),
        .o_flush_ex_n   (flush_ex_n),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc),
        .o_mepc_we      (mepc_we),
        .o_mepc         (mepc),
        .o_mie_clr      (mie_clr),
        .o_mie_set      (mie_set),
        .o_busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [7:0] o,
                                input logic [31:0] rpc, input logic [31:0] mp);
        chk({tag, ".ctl"}, {24'd0, pc_en, flush_id_n, flush_ex_n, redirect,
                            mepc_we, mie_clr, mie_set, busy}, {24'd0, o});
        chk({tag, ".rpc"}, redirect_pc, rpc);
        chk({tag, ".mepc"}, mepc, mp);
    endtask

    initial begin
        rst = 1'b1; irq = 1'b0; mie = 1'b0; ex_valid = 1'b1; pc_sel = 1'b0;
        hazard_stall = 1'b0; mret_ex = 1'b0; mtvec = 32'h103; ex_pc = 32'h0;
        tick(); tick();
        expect_state("reset", O_IDLE, 32'h0, 32'h0);
        rst = 1'b0;

        // Masked interrupt never enters
        irq = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        expect_state("masked20", O_IDLE, 32'h0, 32'h0);

        // Basic entry; irq drops and ex_pc moves during drain
        mie = 1'b1; ex_pc = 32'h40;
        tick();
        expect_state("entry.drain1", O_DRAIN, 32'h0, 32'h40);
        irq = 1'b0; ex_pc = 32'h99;
        tick();
        expect_state("entry.drain2", O_DRAIN, 32'h0, 32'h40);
        tick();
        expect_state("entry.redir", O_REDIR, 32'h100, 32'h40);
        tick();
        expect_state("entry.handler", O_IDLE, 32'h0, 32'h40);

        // irq ignored in handler
        irq = 1'b1;
        tick(); tick(); tick();
        expect_state("handler.irq", O_IDLE, 32'h0, 32'h40);
        irq = 1'b0; mret_ex = 1'b1;
        tick();
        expect_state("ret1", O_RET, 32'h40, 32'h40);
        mret_ex = 1'b0;
        tick();
        expect_state("ret1.idle", O_IDLE, 32'h0, 32'h40);

        // Deferral: bubble, branch, stall each block; first clean cycle enters
        irq = 1'b1; ex_valid = 1'b0; ex_pc = 32'h7c;
        tick();
        expect_state("defer.bubble", O_IDLE, 32'h0, 32'h40);
        ex_valid = 1'b1; pc_sel = 1'b1; ex_pc = 32'h80;
        tick();
        expect_state("defer.branch", O_IDLE, 32'h0, 32'h40);
        pc_sel = 1'b0; hazard_stall = 1'b1; ex_pc = 32'h84;
        tick();
        expect_state("defer.stall", O_IDLE, 32'h0, 32'h40);
        hazard_stall = 1'b0; ex_pc = 32'h88;
        tick();
        expect_state("defer.drain1", O_DRAIN, 32'h0, 32'h88);
        irq = 1'b0;
        tick();
        expect_state("defer.drain2", O_DRAIN, 32'h0, 32'h88);
        tick();
        expect_state("defer.redir", O_REDIR, 32'h100, 32'h88);
        tick();
        mret_ex = 1'b1;
        tick();
        expect_state("ret2", O_RET, 32'h88, 32'h88);
        mret_ex = 1'b0;
        tick();
        expect_state("ret2.idle", O_IDLE, 32'h0, 32'h88);

        // mret beats irq in IDLE
        irq = 1'b1; mret_ex = 1'b1; ex_pc = 32'h200;
        tick();
        expect_state("prio.ret", O_RET, 32'h88, 32'h88);
        irq = 1'b0; mret_ex = 1'b0;
        tick();
        expect_state("prio.idle", O_IDLE, 32'h0, 32'h88);

        // Reset during drain drops the entry
        irq = 1'b1; ex_pc = 32'h300;
        tick();
        expect_state("rst.drain", O_DRAIN, 32'h0, 32'h300);
        irq = 1'b0; rst = 1'b1;
        tick();
        expect_state("rst.applied", O_IDLE, 32'h0, 32'h0);
        rst = 1'b0;
        tick(); tick(); tick();
        expect_state("rst.stays", O_IDLE, 32'h0, 32'h0);

        // mret with no prior entry returns to mepc_q = 0
        mret_ex = 1'b1;
        tick();
        expect_state("ret0", O_RET, 32'h0, 32'h0);
        mret_ex = 1'b0;
        tick();
        expect_state("ret0.idle", O_IDLE, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
